// File: rtl/fifo_wr_ptr_full.sv
// rtl/fifo_wr_ptr_full.sv - write-side pointer, full flag and fill level for the async FIFO
// Optional almost-full output enabled by defining FIFO_ALMOST_FULL_EN.
module fifo_wr_ptr_full #(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 6
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  w_inc,
  input  logic [ADDR_WIDTH:0]   r_ptr_gray,
  output logic                  wclken,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   w_ptr_gray,
  output logic                  w_full,
  output logic [ADDR_WIDTH:0]   w_level
`ifdef FIFO_ALMOST_FULL_EN
  ,
  output logic                  w_almost_full
`endif
);

  generate
    if (SYNC_STAGES < 2 || AF_THRESH < 1 || AF_THRESH >= (1 << ADDR_WIDTH)) begin : g_bad_param
      $error("fifo_wr_ptr_full: illegal SYNC_STAGES or AF_THRESH");
    end
  endgenerate

  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
  logic [ADDR_WIDTH:0] sync_d [SYNC_STAGES];
  logic [ADDR_WIDTH:0] wbin_q, wbin_d;
  logic [ADDR_WIDTH:0] w_ptr_gray_q, w_ptr_gray_d;
  logic                w_full_q, w_full_d;
  logic [ADDR_WIDTH:0] w_level_q, w_level_d;
  logic [ADDR_WIDTH:0] rq_gray;
  logic [ADDR_WIDTH:0] full_gray;

  // Plain flop chain: no logic between stages so each Gray bit resolves independently.
  always_comb begin
    sync_d[0] = r_ptr_gray;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign rq_gray = sync_q[SYNC_STAGES-1];

  // Write pointer one lap ahead of the read pointer: top two Gray bits inverted.
  generate
    if (ADDR_WIDTH == 1) begin : g_narrow
      assign full_gray = ~rq_gray;
    end else begin : g_wide
      assign full_gray = {~rq_gray[ADDR_WIDTH:ADDR_WIDTH-1], rq_gray[ADDR_WIDTH-2:0]};
    end
  endgenerate

  assign wclken = w_inc & ~w_full_q & ~w_rst;

  always_comb begin
    wbin_d       = wbin_q + {{ADDR_WIDTH{1'b0}}, wclken};
    w_ptr_gray_d = wbin_d ^ (wbin_d >> 1);
    w_full_d     = (w_ptr_gray_d == full_gray);
    w_level_d    = wbin_d - gray2bin(rq_gray);
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      wbin_q       <= '0;
      w_ptr_gray_q <= '0;
      w_full_q     <= 1'b0;
      w_level_q    <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      wbin_q       <= wbin_d;
      w_ptr_gray_q <= w_ptr_gray_d;
      w_full_q     <= w_full_d;
      w_level_q    <= w_level_d;
    end
  end

  assign wr_addr    = wbin_q[ADDR_WIDTH-1:0];
  assign w_ptr_gray = w_ptr_gray_q;
  assign w_full     = w_full_q;
  assign w_level    = w_level_q;

`ifdef FIFO_ALMOST_FULL_EN
  logic w_almost_full_q, w_almost_full_d;

  always_comb begin
    w_almost_full_d = (w_level_d >= (ADDR_WIDTH+1)'(AF_THRESH));
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      w_almost_full_q <= 1'b0;
    end else begin
      w_almost_full_q <= w_almost_full_d;
    end
  end

  assign w_almost_full = w_almost_full_q;
`endif

endmodule

// File: tb/tb_fifo_wr_ptr_full.sv
// tb/tb_fifo_wr_ptr_full.sv - self-checking bench for fifo_wr_ptr_full
// Define FIFO_ALMOST_FULL_EN to also check w_almost_full.
module tb_fifo_wr_ptr_full;
  localparam int A     = 3;
  localparam int S     = 2;
  localparam int AFT   = 6;
  localparam int DEPTH = 1 << A;
  localparam int MOD   = 2 * DEPTH;

  logic         w_clk = 1'b0;
  logic         w_rst = 1'b1;
  logic         w_inc = 1'b0;
  logic [A:0]   r_ptr_gray = '0;
  logic         wclken;
  logic [A-1:0] wr_addr;
  logic [A:0]   w_ptr_gray;
  logic         w_full;
  logic [A:0]   w_level;
`ifdef FIFO_ALMOST_FULL_EN
  logic         w_almost_full;
`endif

  fifo_wr_ptr_full #(.ADDR_WIDTH(A), .SYNC_STAGES(S), .AF_THRESH(AFT)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_inc(w_inc), .r_ptr_gray(r_ptr_gray),
    .wclken(wclken), .wr_addr(wr_addr), .w_ptr_gray(w_ptr_gray),
    .w_full(w_full), .w_level(w_level)
`ifdef FIFO_ALMOST_FULL_EN
    , .w_almost_full(w_almost_full)
`endif
  );

  always #5 w_clk = ~w_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: counts of writes and the read pointer as seen after the synchronizer delay.
  int m_total;      // writes accepted since reset
  int m_rq;         // read count visible to the write side
  int m_rq_hist[$]; // read counts presented at recent edges
  int m_level;
  bit m_full;

  function automatic logic [A:0] to_gray(input int v);
    logic [A:0] b;
    b = v[A:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_total = 0;
    m_rq    = 0;
    m_level = 0;
    m_full  = 0;
    m_rq_hist.delete();
  endtask

  task automatic check_regs();
    chk("wr_addr",    32'(wr_addr),    32'(m_total % DEPTH));
    chk("w_ptr_gray", 32'(w_ptr_gray), 32'(to_gray(m_total % MOD)));
    chk("w_full",     32'(w_full),     32'(m_full));
    chk("w_level",    32'(w_level),    32'(m_level));
`ifdef FIFO_ALMOST_FULL_EN
    chk("w_almost_full", 32'(w_almost_full), 32'(m_level >= AFT));
`endif
  endtask

  // One cycle: drive inputs, check the combinational enable, clock, check registered outputs.
  task automatic step(input bit inc, input int rd);
    bit acc;
    int rq_before;
    w_inc      = inc;
    r_ptr_gray = to_gray(rd % MOD);
    #1;
    acc = inc && !m_full;
    chk("wclken", 32'(wclken), 32'(acc));
    @(posedge w_clk);
    rq_before = m_rq;
    m_total   = m_total + int'(acc);
    m_level   = (m_total - rq_before) & (MOD - 1);
    m_full    = (m_level == DEPTH);
    m_rq_hist.push_back(rd % MOD);
    if (m_rq_hist.size() > S) void'(m_rq_hist.pop_front());
    m_rq = (m_rq_hist.size() == S) ? m_rq_hist[0] : 0;
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    w_inc = 1'b0;
    w_rst = 1'b1;
    @(posedge w_clk);
    @(posedge w_clk);
    #1;
    w_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int acc_cnt;
    int rd;
    model_reset();
    #2;
    chk("rst_w_full",    32'(w_full),     32'd0);
    chk("rst_wr_addr",   32'(wr_addr),    32'd0);
    chk("rst_w_level",   32'(w_level),    32'd0);
    chk("rst_wclken",    32'(wclken),     32'd0);
    @(posedge w_clk);
    #1;
    w_rst = 1'b0;

    // Reset asserted mid-run with wbin=5.
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("pre_rst_wr_addr", 32'(wr_addr), 32'd5);
    w_inc = 1'b1;
    w_rst = 1'b1;
    #1;
    chk("async_rst_gray",   32'(w_ptr_gray), 32'd0);
    chk("async_rst_addr",   32'(wr_addr),    32'd0);
    chk("async_rst_full",   32'(w_full),     32'd0);
    chk("async_rst_wclken", 32'(wclken),     32'd0);
    do_reset();
    chk("post_rst_addr", 32'(wr_addr), 32'd0);
    step(1, 0);

    // Fill from empty with the reader parked at 0.
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) chk("fill_addr", 32'(wr_addr), 32'(i));
      w_inc = 1'b1;
      #1;
      acc_cnt += int'(wclken);
      step(1, 0);
`ifdef FIFO_ALMOST_FULL_EN
      chk("fill_af", 32'(w_almost_full), 32'(i >= 5));
`endif
    end
    chk("fill_accepts", 32'(acc_cnt), 32'd8);
    chk("fill_full",    32'(w_full),     32'd1);
    chk("fill_level",   32'(w_level),    32'd8);
    chk("fill_gray",    32'(w_ptr_gray), 32'b1100);

    // Writes held against a full FIFO are dropped.
    for (int i = 0; i < 5; i++) step(1, 0);
    chk("drop_gray", 32'(w_ptr_gray), 32'b1100);
    chk("drop_addr", 32'(wr_addr),    32'd0);

    // Reader advances to 1: full must clear on exactly the third edge.
    step(0, 1);
    chk("unblock_e1", 32'(w_full), 32'd1);
    step(0, 1);
    chk("unblock_e2", 32'(w_full), 32'd1);
    step(0, 1);
    chk("unblock_e3",    32'(w_full),  32'd0);
    chk("unblock_level", 32'(w_level), 32'd7);
    chk("unblock_addr",  32'(wr_addr), 32'd0);
    step(1, 1);

    // Wrap: 20 writes with the reader two entries behind.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      rd = (m_total >= 2) ? m_total - 2 : 0;
      step(1, rd);
      chk("wrap_no_full", 32'(w_full), 32'd0);
    end
    chk("wrap_gray", 32'(w_ptr_gray), 32'(to_gray(20 % MOD)));

    // Random producer and a legal reader that never passes the writer.
    do_reset();
    rd = 0;
    for (int i = 0; i < 400; i++) begin
      if (rd < m_total && $urandom_range(0, 99) < 40) rd++;
      step(bit'($urandom_range(0, 99) < 60), rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fifo_wr_ptr_full.md
Name: fifo_wr_ptr_full

Overview:
Write-side pointer and full-flag controller for the async FIFO. It sits directly upstream of the FIFO memory controller and drives its write enable and write address. It accepts write requests from the producer and synchronizes the read-domain Gray pointer into w_clk. It produces the write-domain Gray pointer for the read side, plus the full flag and fill level. Single clock domain (w_clk).

Parameters:
- ADDR_WIDTH, 3: memory address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- SYNC_STAGES, 2: flop stages in the r_ptr_gray synchronizer; legal values are ≥2.
- AF_THRESH, 6: almost-full level, used only when FIFO_ALMOST_FULL_EN is defined; legal range 1..2^ADDR_WIDTH-1.

Ports:
- w_clk  in  1  write clock; all state changes on its rising edge.
- w_rst  in  1  reset; asynchronous, active-high.
- w_inc  in  1  producer write request for the current cycle.
- r_ptr_gray  in  ADDR_WIDTH+1  read pointer in Gray code; arrives from the read domain, unsynchronized.
- wclken  out  1  write enable to the memory controller.
- wr_addr  out  ADDR_WIDTH  write address to the memory controller.
- w_ptr_gray  out  ADDR_WIDTH+1  registered write pointer in Gray code, sent to the read-side synchronizer.
- w_full  out  1  registered full flag.
- w_level  out  ADDR_WIDTH+1  occupancy as seen from the write side; range 0..2^ADDR_WIDTH.
- w_almost_full  out  1  present only when FIFO_ALMOST_FULL_EN is defined.

Behaviour:
- Reset (w_rst=1, asynchronous assert):
  - wbin, w_ptr_gray and all synchronizer flops go to 0.
  - Outputs: w_full=0, wr_addr=0, w_level=0, w_almost_full=0.
  - wclken=0 because of the reset value of w_full plus the w_rst gate below.
- Release: synchronous to w_clk. Reset asserted mid-operation discards all pointer state immediately; memory contents are not this block's concern.
- Synchronizer: r_ptr_gray passes through SYNC_STAGES flops, giving rq_gray. No logic between the stages.
- wclken is combinational: w_inc & ~w_full & ~w_rst. A write is accepted in the same cycle it is requested. Memory captures the data at the same edge that the pointer advances.
- wr_addr = wbin[ADDR_WIDTH-1:0], taken from a register (no combinational path from w_inc).
- Each edge:
  - wbin_next = wbin + wclken, modulo 2^(ADDR_WIDTH+1).
  - w_ptr_gray <= wbin_next ^ (wbin_next >> 1).
- Full, registered:
  - w_full <= (wgray_next == {~rq_gray[A:A-1], rq_gray[A-2:0]}), where A = ADDR_WIDTH.
  - When ADDR_WIDTH=1, compare against ~rq_gray[1:0] for the top bits.
- Write while full: a write with w_full=1 is dropped. wbin does not change and wclken=0. No error flag is raised.
- Full clearing: w_full clears only after the read pointer change has propagated. That is SYNC_STAGES edges for rq_gray to update, plus 1 edge for the registered compare.
- Conservative full: w_full may be pessimistic (stay set longer than needed) but is never optimistic.
- w_level, registered: w_level <= wbin_next - gray2bin(rq_gray), modulo 2^(ADDR_WIDTH+1).
- Wrap-around: wbin rolls from 2^(A+1)-1 to 0 with no discontinuity in the Gray sequence. wr_addr wraps every 2^A writes.
- Simultaneous write and read-pointer update in one cycle: full is computed from wgray_next against the current rq_gray; there is no special case.

Optional Feature:
- Macro: FIFO_ALMOST_FULL_EN.
- Defined:
  - w_almost_full <= (level_next >= AF_THRESH), where level_next is the same value being loaded into w_level.
  - Reset value 0.
  - Registered; same latency as w_full.
- Undefined: the w_almost_full port and its logic are absent. AF_THRESH is ignored.

Test Plan:
All cases use ADDR_WIDTH=3 and SYNC_STAGES=2 unless stated.

1. Reset check: assert w_rst mid-run with wbin=5 → in the same cycle, w_ptr_gray=0, wr_addr=0, w_full=0, wclken=0. After release, the first write goes to wr_addr=0.
2. Fill: r_ptr_gray=0, w_inc=1 for 9 cycles →
   - wclken=1 for exactly 8 cycles; wr_addr runs 0..7.
   - w_full=1 after the 8th edge; w_level=8; w_ptr_gray=4'b1100.
   - 9th request is dropped.
3. Unblock: from full, set r_ptr_gray=4'b0001 (read pointer = 1) → w_full=0 exactly 3 edges later; w_level=7; the next w_inc write goes to wr_addr=0.
4. Wrap: 20 writes, with r_ptr_gray tracking the write pointer 2 entries behind →
   - w_ptr_gray follows the Gray sequence 0000..1000..0000 and then continues.
   - wbin wraps 15→0; w_full is never set.
5. Dropped-write accounting: while full, hold w_inc=1 for 5 cycles → wbin, wr_addr and w_ptr_gray unchanged; wclken stays 0.
6. FIFO_ALMOST_FULL_EN, AF_THRESH=6: writes with r_ptr_gray=0 → w_almost_full=1 after the 6th write edge. It drops to 0 when rq_gray reflects read pointer 1 at level 5.
